// File: rtl/interp_sched_if.sv
`default_nettype none
// ============================================================================
// interp_sched_if : triangle command, shared-interpolator and coefficient-beat
//                   signal bundle for interp_sched.          Revision: 1.0
// ============================================================================
interface interp_sched_if #(
  parameter int NCH = 3
);
  logic              tri_valid;
  logic              tri_ready;
  logic [71:0]       tri_xy;
  logic [36*NCH-1:0] tri_s;
  logic [71:0]       ip_xy;
  logic [35:0]       ip_s;
  logic [23:0]       ip_cx;
  logic [23:0]       ip_cy;
  logic [23:0]       ip_cs;
  logic              coef_valid;
  logic              coef_ready;
  logic [2:0]        coef_ch;
  logic [23:0]       coef_cx;
  logic [23:0]       coef_cy;
  logic [23:0]       coef_cs;
  logic              coef_last;
  logic              degen;
  logic              busy;

  modport slave (
    input  tri_valid, tri_xy, tri_s, ip_cx, ip_cy, ip_cs, coef_ready,
    output tri_ready, ip_xy, ip_s, coef_valid, coef_ch, coef_cx, coef_cy,
           coef_cs, coef_last, degen, busy
  );

  modport master (
    output tri_valid, tri_xy, tri_s, ip_cx, ip_cy, ip_cs, coef_ready,
    input  tri_ready, ip_xy, ip_s, coef_valid, coef_ch, coef_cx, coef_cy,
           coef_cs, coef_last, degen, busy
  );
endinterface
`default_nettype wire

// File: rtl/interp_sched.sv
`default_nettype none
// ============================================================================
// interp_sched : sequences one triangle's attribute channels through a shared
//                combinational interpolator and emits coefficient beats. Rev 1.0
// ============================================================================
module interp_sched #(
  parameter int NCH    = 3,
  parameter int SETTLE = 4
) (
  input  wire            clk,
  input  wire            rst_b,
  interp_sched_if.slave  bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_DEGEN  = 3'd4;

  localparam int            CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] c_CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [2:0]    c_LAST_CH  = 3'(NCH - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [71:0]       xy_q, xy_d;
  logic [36*NCH-1:0] s_q, s_d;
  logic [23:0]       cx_q, cx_d;
  logic [23:0]       cy_q, cy_d;
  logic [23:0]       cs_q, cs_d;

  // 12-bit unsigned coordinates: differences need 13 bits, products 25, sum 27.
  logic signed [27:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
  logic signed [27:0] w_det;
  logic [35:0]        w_ip_s;

  assign w_x0  = $signed({16'd0, xy_q[11:0]});
  assign w_y0  = $signed({16'd0, xy_q[23:12]});
  assign w_x1  = $signed({16'd0, xy_q[35:24]});
  assign w_y1  = $signed({16'd0, xy_q[47:36]});
  assign w_x2  = $signed({16'd0, xy_q[59:48]});
  assign w_y2  = $signed({16'd0, xy_q[71:60]});
  assign w_det = w_x0 * (w_y1 - w_y2) + w_x1 * (w_y2 - w_y0) + w_x2 * (w_y0 - w_y1);

  always_comb begin
    w_ip_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == 3'(k)) w_ip_s = s_q[36*k +: 36];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    xy_d    = xy_q;
    s_d     = s_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cs_d    = cs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.tri_valid) begin
          xy_d    = bus.tri_xy;
          s_d     = bus.tri_s;
          ch_d    = 3'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_det == 28'sd0) begin
          // The degenerate beat carries zero coefficients.
          cx_d    = '0;
          cy_d    = '0;
          cs_d    = '0;
          state_d = S_DEGEN;
        end else begin
          cnt_d   = c_CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cx_d    = bus.ip_cx;
          cy_d    = bus.ip_cy;
          cs_d    = bus.ip_cs;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OUT: begin
        if (bus.coef_ready) begin
          if (ch_q == c_LAST_CH) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + 3'd1;
            cnt_d   = c_CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
      end
      S_DEGEN: begin
        if (bus.coef_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      ch_q    <= 3'd0;
      cnt_q   <= '0;
      xy_q    <= '0;
      s_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      xy_q    <= xy_d;
      s_q     <= s_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cs_q    <= cs_d;
    end
  end

  assign bus.tri_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ip_xy      = xy_q;
  assign bus.ip_s       = w_ip_s;
  assign bus.coef_valid = (state_q == S_OUT) || (state_q == S_DEGEN);
  assign bus.degen      = (state_q == S_DEGEN);
  assign bus.coef_last  = ((state_q == S_OUT) && (ch_q == c_LAST_CH)) || (state_q == S_DEGEN);
  assign bus.coef_ch    = ch_q;
  assign bus.coef_cx    = cx_q;
  assign bus.coef_cy    = cy_q;
  assign bus.coef_cs    = cs_q;
endmodule
`default_nettype wire

// File: tb/tb_interp_sched.sv
`default_nettype none
// Randomized self-checking bench for interp_sched; a behavioural interpolator
// model only presents correct results once its inputs have been stable SETTLE cycles.
module tb_interp_sched;
  localparam int NCH    = 3;
  localparam int SETTLE = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  interp_sched_if #(.NCH(NCH)) bus ();

  interp_sched #(.NCH(NCH), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] interp_model(input logic [71:0] xy, input logic [35:0] s);
    int x0, y0, x1, y1, x2, y2, s0, s1, s2, nx, ny, ns;
    x0 = int'(xy[11:0]);  y0 = int'(xy[23:12]);
    x1 = int'(xy[35:24]); y1 = int'(xy[47:36]);
    x2 = int'(xy[59:48]); y2 = int'(xy[71:60]);
    s0 = int'(s[11:0]);   s1 = int'(s[23:12]);  s2 = int'(s[35:24]);
    nx = s0 * (y1 - y2) + s1 * (y2 - y0) + s2 * (y0 - y1);
    ny = s0 * (x2 - x1) + s1 * (x0 - x2) + s2 * (x1 - x0);
    ns = s0 + 3 * s1 + 5 * s2 + x0 * y1 - x1 * y0;
    return {nx[23:0], ny[23:0], ns[23:0]};
  endfunction

  function automatic longint det_of(input logic [71:0] xy);
    longint x0, y0, x1, y1, x2, y2;
    x0 = longint'(xy[11:0]);  y0 = longint'(xy[23:12]);
    x1 = longint'(xy[35:24]); y1 = longint'(xy[47:36]);
    x2 = longint'(xy[59:48]); y2 = longint'(xy[71:60]);
    return x0 * (y1 - y2) + x1 * (y2 - y0) + x2 * (y0 - y1);
  endfunction

  function automatic logic [36*NCH-1:0] rand_s();
    logic [36*NCH-1:0] s;
    for (int k = 0; k < 3 * NCH; k++) s[12*k +: 12] = 12'($urandom);
    return s;
  endfunction

  function automatic logic [71:0] rand_xy(input bit collinear);
    int px, py, dx, dy;
    if (!collinear) return {12'($urandom), 12'($urandom), 12'($urandom),
                            12'($urandom), 12'($urandom), 12'($urandom)};
    px = 300 + int'($urandom_range(0, 2700)); py = 300 + int'($urandom_range(0, 2700));
    dx = int'($urandom_range(0, 200)) - 100;  dy = int'($urandom_range(0, 200)) - 100;
    return {12'(py + 2 * dy), 12'(px + 2 * dx), 12'(py + dy), 12'(px + dx), 12'(py), 12'(px)};
  endfunction

  // Interpolator model: outputs are garbage until inputs have been stable SETTLE cycles.
  logic [71:0] m_xy_last;
  logic [35:0] m_s_last;
  int          m_age = 100;
  always @(negedge clk) begin
    logic [71:0] r;
    if (bus.ip_xy !== m_xy_last || bus.ip_s !== m_s_last) m_age = 1;
    else if (m_age < 1000) m_age++;
    m_xy_last = bus.ip_xy;
    m_s_last  = bus.ip_s;
    r = interp_model(bus.ip_xy, bus.ip_s);
    if (m_age < SETTLE) r = ~r;
    bus.ip_cx = r[71:48];
    bus.ip_cy = r[47:24];
    bus.ip_cs = r[23:0];
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.tri_ready, bus.busy, bus.coef_valid, bus.degen, bus.coef_last} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/busy/vld/deg/last=%b want 10000",
               {bus.tri_ready, bus.busy, bus.coef_valid, bus.degen, bus.coef_last});
    end
    n_vec++;
    if ({bus.ip_xy, bus.ip_s, bus.coef_ch} !== '0) begin
      n_err++;
      $display("FAIL reset_ip: got ip_xy=%h ip_s=%h ch=%0d want all 0", bus.ip_xy, bus.ip_s, bus.coef_ch);
    end
    n_vec++;
    if ({bus.coef_cx, bus.coef_cy, bus.coef_cs} !== 72'd0) begin
      n_err++;
      $display("FAIL reset_coef: got %h want 0", {bus.coef_cx, bus.coef_cy, bus.coef_cs});
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [71:0] xy, e;
    logic [36*NCH-1:0] s;
    int acc, k;
    xy = {12'd16, 12'd0, 12'd0, 12'd16, 12'd0, 12'd0};
    s  = rand_s();
    bus.tri_xy = xy; bus.tri_s = s; bus.tri_valid = 1'b1; bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    acc = cyc;
    n_vec++;
    if ({bus.tri_ready, bus.busy} !== 2'b01) begin
      n_err++; $display("FAIL nominal_busy: got rdy/busy=%b want 01", {bus.tri_ready, bus.busy});
    end
    k = 0;
    for (int t = 0; t < 100 && k < NCH; t++) begin
      if (bus.coef_valid) begin
        e = interp_model(xy, s[36*k +: 36]);
        n_vec++;
        if ({bus.coef_ch, bus.coef_last, bus.degen} !== {3'(k), k == NCH - 1, 1'b0}) begin
          n_err++;
          $display("FAIL nominal_ctl: got ch/last/degen=%0d/%b/%b want %0d/%b/0",
                   bus.coef_ch, bus.coef_last, bus.degen, k, k == NCH - 1);
        end
        n_vec++;
        if ({bus.coef_cx, bus.coef_cy, bus.coef_cs} !== e) begin
          n_err++; $display("FAIL nominal_data ch%0d: got %h want %h", k, {bus.coef_cx, bus.coef_cy, bus.coef_cs}, e);
        end
        n_vec++;
        if (cyc + 1 - acc != SETTLE + 2 + k * (SETTLE + 1)) begin
          n_err++;
          $display("FAIL nominal_latency ch%0d: got %0d edges want %0d", k, cyc + 1 - acc, SETTLE + 2 + k * (SETTLE + 1));
        end
        k++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (k != NCH || {bus.tri_ready, bus.busy} !== 2'b10) begin
      n_err++;
      $display("FAIL nominal_end: got beats=%0d rdy/busy=%b want %0d/10", k, {bus.tri_ready, bus.busy}, NCH);
    end
  endtask

  task automatic test_degenerate();
    logic [71:0] xy;
    logic [36*NCH-1:0] s;
    int acc, nb;
    xy = {12'd16, 12'd16, 12'd8, 12'd8, 12'd0, 12'd0};
    s  = rand_s();
    bus.tri_xy = xy; bus.tri_s = s; bus.tri_valid = 1'b1; bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    acc = cyc;
    nb  = 0;
    for (int t = 0; t < 12; t++) begin
      n_vec++;
      if (bus.ip_s !== s[35:0]) begin
        n_err++; $display("FAIL degen_ip_s: got %h want %h", bus.ip_s, s[35:0]);
      end
      if (bus.coef_valid) begin
        nb++;
        n_vec++;
        if ({bus.degen, bus.coef_last, bus.coef_ch, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {2'b11, 75'd0}) begin
          n_err++;
          $display("FAIL degen_beat: got deg/last=%b%b ch=%0d coefs=%h want 11/0/0",
                   bus.degen, bus.coef_last, bus.coef_ch, {bus.coef_cx, bus.coef_cy, bus.coef_cs});
        end
        n_vec++;
        if (cyc + 1 - acc != 2) begin
          n_err++; $display("FAIL degen_latency: got %0d edges want 2", cyc + 1 - acc);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (nb != 1) begin
      n_err++; $display("FAIL degen_count: got %0d beats want 1", nb);
    end
  endtask

  task automatic test_backpressure();
    logic [71:0] xy, e;
    logic [36*NCH-1:0] s;
    logic [76:0] snap;
    int h, t;
    xy = {12'd16, 12'd0, 12'd0, 12'd16, 12'd0, 12'd0};
    s  = rand_s();
    bus.tri_xy = xy; bus.tri_s = s; bus.tri_valid = 1'b1; bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    for (t = 0; t < 20 && !bus.coef_valid; t++) @(negedge clk);
    @(negedge clk);
    bus.coef_ready = 1'b0;
    for (t = 0; t < 20 && !bus.coef_valid; t++) @(negedge clk);
    e = interp_model(xy, s[36 +: 36]);
    n_vec++;
    if ({bus.coef_valid, bus.coef_ch, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {1'b1, 3'd1, e}) begin
      n_err++;
      $display("FAIL bp_ch1: got vld=%b ch=%0d coefs=%h want 1/1/%h",
               bus.coef_valid, bus.coef_ch, {bus.coef_cx, bus.coef_cy, bus.coef_cs}, e);
    end
    snap = {bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.coef_valid, bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {1'b1, snap}) begin
        n_err++; $display("FAIL bp_stable: got vld=%b beat=%h want 1/%h", bus.coef_valid,
                          {bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs}, snap);
      end
      n_vec++;
      if (bus.ip_s !== s[36 +: 36]) begin
        n_err++; $display("FAIL bp_ip_s: got %h want %h", bus.ip_s, s[36 +: 36]);
      end
    end
    bus.coef_ready = 1'b1;
    h = cyc + 1;
    @(negedge clk);
    for (t = 0; t < 20 && !bus.coef_valid; t++) @(negedge clk);
    e = interp_model(xy, s[72 +: 36]);
    n_vec++;
    if (cyc - h != SETTLE) begin
      n_err++; $display("FAIL bp_ch2_latency: got %0d edges want %0d", cyc - h, SETTLE);
    end
    n_vec++;
    if ({bus.coef_ch, bus.coef_last, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {3'd2, 1'b1, e}) begin
      n_err++; $display("FAIL bp_ch2: got ch=%0d last=%b coefs=%h want 2/1/%h",
                        bus.coef_ch, bus.coef_last, {bus.coef_cx, bus.coef_cy, bus.coef_cs}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [71:0] xa, xb, e;
    logic [36*NCH-1:0] sa, sb, ss;
    int acc2, fin, j;
    xa = rand_xy(1'b0); xb = rand_xy(1'b0);
    if (det_of(xa) == 0) xa = {12'd16, 12'd0, 12'd0, 12'd16, 12'd0, 12'd0};
    if (det_of(xb) == 0) xb = {12'd9, 12'd1, 12'd2, 12'd30, 12'd0, 12'd0};
    sa = rand_s(); sb = rand_s();
    bus.tri_xy = xa; bus.tri_s = sa; bus.tri_valid = 1'b1; bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.tri_xy = xb; bus.tri_s = sb;
    acc2 = -1; fin = -1; j = 0;
    for (int t = 0; t < 200 && j < 2 * NCH; t++) begin
      if (acc2 >= 0 && cyc >= acc2) bus.tri_valid = 1'b0;
      if (bus.tri_ready && acc2 < 0) begin
        acc2 = cyc + 1;
        n_vec++;
        if (fin < 0 || acc2 != fin + 1) begin
          n_err++; $display("FAIL b2b_accept: got accept edge %0d want %0d", acc2, fin + 1);
        end
      end
      if (bus.coef_valid) begin
        ss = (j < NCH) ? sa : sb;
        e  = interp_model((j < NCH) ? xa : xb, ss[36*(j % NCH) +: 36]);
        n_vec++;
        if ({bus.coef_ch, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {3'(j % NCH), e}) begin
          n_err++; $display("FAIL b2b_beat%0d: got ch=%0d coefs=%h want %0d/%h", j, bus.coef_ch,
                            {bus.coef_cx, bus.coef_cy, bus.coef_cs}, j % NCH, e);
        end
        if (j == NCH - 1) fin = cyc + 1;
        j++;
      end
      @(negedge clk);
    end
    bus.tri_valid = 1'b0;
    n_vec++;
    if (j != 2 * NCH) begin
      n_err++; $display("FAIL b2b_count: got %0d beats want %0d", j, 2 * NCH);
    end
  endtask

  task automatic test_reset_mid_out();
    bus.tri_xy = {12'd16, 12'd0, 12'd0, 12'd16, 12'd0, 12'd0}; bus.tri_s = rand_s();
    bus.tri_valid = 1'b1; bus.coef_ready = 1'b0;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    for (int t = 0; t < 20 && !bus.coef_valid; t++) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_vec++;
    if ({bus.coef_valid, bus.tri_ready, bus.busy, bus.ip_s} !== {3'b010, 36'd0}) begin
      n_err++; $display("FAIL rst_mid_out: got vld/rdy/busy=%b ip_s=%h want 010/0",
                        {bus.coef_valid, bus.tri_ready, bus.busy}, bus.ip_s);
    end
    @(negedge clk);
    rst_b = 1'b1;
    bus.coef_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_settle();
    logic [71:0] xy, e;
    logic [36*NCH-1:0] s;
    int nv, k;
    bus.tri_xy = {12'd16, 12'd0, 12'd0, 12'd16, 12'd0, 12'd0}; bus.tri_s = rand_s();
    bus.tri_valid = 1'b1; bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    for (int t = 0; t < 20 && !bus.coef_valid; t++) @(negedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    nv = 0;
    for (int t = 0; t < 12; t++) begin
      if (bus.coef_valid || !bus.tri_ready) nv++;
      @(negedge clk);
    end
    n_vec++;
    if (nv != 0) begin
      n_err++; $display("FAIL rst_settle_quiet: got %0d busy/valid cycles want 0", nv);
    end
    xy = {12'd40, 12'd5, 12'd3, 12'd50, 12'd7, 12'd2};
    s  = rand_s();
    bus.tri_xy = xy; bus.tri_s = s; bus.tri_valid = 1'b1;
    @(negedge clk);
    bus.tri_valid = 1'b0;
    k = 0;
    for (int t = 0; t < 100 && k < NCH; t++) begin
      if (bus.coef_valid) begin
        e = interp_model(xy, s[36*k +: 36]);
        n_vec++;
        if ({bus.coef_ch, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {3'(k), e}) begin
          n_err++; $display("FAIL rst_settle_beat%0d: got ch=%0d coefs=%h want %0d/%h", k, bus.coef_ch,
                            {bus.coef_cx, bus.coef_cy, bus.coef_cs}, k, e);
        end
        k++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (k != NCH) begin
      n_err++; $display("FAIL rst_settle_count: got %0d beats want %0d", k, NCH);
    end
  endtask

  task automatic test_random();
    logic [71:0] xy, e;
    logic [36*NCH-1:0] s;
    logic [76:0] snap;
    bit dg, hold;
    int nb, k;
    for (int n = 0; n < 16; n++) begin
      xy = rand_xy($urandom_range(0, 3) == 0);
      s  = rand_s();
      dg = (det_of(xy) == 0);
      nb = dg ? 1 : NCH;
      bus.tri_xy = xy; bus.tri_s = s; bus.tri_valid = 1'b1; bus.coef_ready = 1'b0;
      @(negedge clk);
      bus.tri_valid = 1'b0;
      k = 0; hold = 1'b0; snap = '0;
      for (int t = 0; t < 400 && k < nb; t++) begin
        n_vec++;
        if (bus.tri_ready !== 1'b0) begin
          n_err++; $display("FAIL rand_ready_busy: got %b want 0", bus.tri_ready);
        end
        if (hold) begin
          n_vec++;
          if ({bus.coef_valid, bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs} !== {1'b1, snap}) begin
            n_err++; $display("FAIL rand_stable: got %h want %h",
                              {bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs}, snap);
          end
        end
        bus.coef_ready = ($urandom_range(0, 99) < 60);
        hold = bus.coef_valid && !bus.coef_ready;
        snap = {bus.coef_ch, bus.coef_last, bus.degen, bus.coef_cx, bus.coef_cy, bus.coef_cs};
        if (bus.coef_valid && bus.coef_ready) begin
          e = dg ? 72'd0 : interp_model(xy, s[36*k +: 36]);
          n_vec++;
          if (snap !== {3'(k), k == nb - 1, dg, e}) begin
            n_err++; $display("FAIL rand_beat tri%0d ch%0d: got %h want %h", n, k, snap, {3'(k), k == nb - 1, dg, e});
          end
          k++;
        end
        @(negedge clk);
      end
      n_vec++;
      if (k != nb || bus.tri_ready !== 1'b1) begin
        n_err++; $display("FAIL rand_end tri%0d: got beats=%0d rdy=%b want %0d/1", n, k, bus.tri_ready, nb);
      end
    end
  endtask

  initial begin
    bus.tri_valid = 1'b0; bus.tri_xy = '0; bus.tri_s = '0; bus.coef_ready = 1'b0;
    test_reset();
    test_nominal();
    test_degenerate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_out();
    test_reset_settle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/interp_sched.md
INTERP_SCHED -- requirements
Module: interp_sched

Interface
REQ-001 The module SHALL have parameter NCH, default 3, giving the number of attribute channels per triangle (1..8).
REQ-002 The module SHALL have parameter SETTLE, default 4, giving the cycles allowed for the combinational interpolator to settle (>=1).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_b  in  1  asynchronous, active-low reset.
REQ-005 tri_valid  in  1  triangle command valid.
REQ-006 tri_ready  out  1  block can accept a triangle.
REQ-007 tri_xy  in  72  packed {y2,x2,y1,x1,y0,x0}, 12-bit unsigned each.
REQ-008 tri_s  in  36*NCH  per-vertex attribute values; channel k, vertex v at bits [36k+12v+11 : 36k+12v].
REQ-009 ip_xy  out  72  vertex bus to the shared interpolator, same packing as tri_xy.
REQ-010 ip_s  out  36  {s2,s1,s0} of the channel being processed.
REQ-011 ip_cx, ip_cy, ip_cs  in  24 each  interpolator results.
REQ-012 coef_valid  out  1  coefficient beat valid.
REQ-013 coef_ready  in  1  consumer accepts a beat.
REQ-014 coef_ch  out  3  channel index of the current beat.
REQ-015 coef_cx, coef_cy, coef_cs  out  24 each  captured coefficients.
REQ-016 coef_last  out  1  final beat of the triangle.
REQ-017 degen  out  1  triangle has zero area; beat carries no coefficients.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, CHECK, SETTLE, OUT and DEGEN.
REQ-020 IDLE: tri_ready=1; on tri_valid&&tri_ready, register tri_xy and tri_s, clear ch to 0, and go to CHECK.
REQ-021 tri_ready SHALL be 0 in all other states; no command is accepted while busy.
REQ-022 CHECK (1 cycle): compute det = x0(y1-y2)+x1(y2-y0)+x2(y0-y1) from the registered vertices, signed, at least 26 bits, with no truncation.
REQ-023 CHECK exit: det==0 goes to DEGEN; otherwise load the settle counter with SETTLE-1 and go to SETTLE.
REQ-024 ip_xy SHALL equal the registered vertices, and ip_s the registered channel-ch values, from CHECK onward.
REQ-025 ip_xy and ip_s SHALL hold their last values in IDLE and be 0 after reset.
REQ-026 SETTLE: decrement the counter each cycle.
REQ-027 When the counter reaches 0, capture ip_cx/ip_cy/ip_cs into coef_cx/cy/cs and go to OUT.
REQ-028 Latency: coef_valid SHALL rise SETTLE+2 edges after the accepting edge (6 for SETTLE=4).
REQ-029 OUT: coef_valid=1, coef_ch=ch, coef_last=(ch==NCH-1), degen=0.
REQ-030 OUT: all coef outputs SHALL be stable while coef_valid&&!coef_ready.
REQ-031 OUT handshake with ch==NCH-1 SHALL go to IDLE.
REQ-032 OUT handshake with ch<NCH-1 SHALL increment ch and reload the counter to SETTLE-1.
REQ-033 After an OUT handshake with ch<NCH-1, ip_s SHALL switch to the new channel on the same edge and the FSM SHALL go to SETTLE.
REQ-034 DEGEN: one beat with coef_valid=1, degen=1, coef_last=1, coef_ch=0 and coef_cx/cy/cs=0, held until coef_ready; then go to IDLE.
REQ-035 DEGEN: no SETTLE cycles SHALL occur.
REQ-036 A triangle SHALL produce exactly NCH beats (ch 0..NCH-1 in order) or exactly one degenerate beat.
REQ-037 A tri_valid asserted during the final handshake cycle SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-038 rst_b low SHALL asynchronously force: state=IDLE, tri_ready=1, coef_valid=0, busy=0, degen=0, coef_last=0, ch=0, counter=0, and all data outputs and registers to 0.
REQ-039 Reset mid-triangle SHALL discard the triangle without emitting a partial beat; the first triangle after release starts at ch 0.

Verification
REQ-040 Reset: assert rst_b=0 mid-OUT -> coef_valid drops before the next edge; tri_ready=1, busy=0.
REQ-041 Nominal: tri (0,0),(16,0),(0,16) with NCH=3, SETTLE=4 and coef_ready=1 -> det=256; beats ch 0,1,2 at 6, 11 and 16 edges after accept.
REQ-042 Nominal data check: each beat equals the model interpolator output for that channel; coef_last only on ch 2; tri_ready returns the cycle after it.
REQ-043 Degenerate: tri (0,0),(8,8),(16,16) -> one beat with degen=1, coef_last=1 and coefs=0, two edges after accept; ip_s never leaves channel 0.
REQ-044 Backpressure: hold coef_ready=0 for 10 cycles on ch 1 -> coef_* bit-stable, ip_s stays on ch 1, ch 2 beat follows SETTLE+0 edges... SETTLE edges after the release handshake.
REQ-045 Busy/reset: tri_valid held high continuously -> second triangle accepted only in IDLE, back-to-back.
REQ-046 Busy/reset: rst_b pulsed during SETTLE of ch 1 -> no beat emitted; next triangle yields beats starting at ch 0.
